dnn_mem_arb: RTL
================

# dnn_mem_arb

Memory-read arbiter and address sequencer for the DNN block loaders. It shares one 8×64-bit block-read memory port between the weight loader and the image loader. Each loader signals a next-block request with a single-cycle pulse and carries no address. The arbiter keeps a block-address pointer per requester, issues the reads round-robin, captures the returned block, and pulses the owner's ready strobe with the data.

## Interface
- ADDR_W, 32: width of block addresses; one address step equals one 8×64-bit block.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load base pointers and clear flags; honoured only in IDLE.
- wt_base  in  ADDR_W  first block address of the weight stream.
- img_base  in  ADDR_W  first block address of the image stream.
- wt_req  in  1  single-cycle next-block request from the weight loader.
- img_req  in  1  single-cycle next-block request from the image loader.
- wt_ready  out  1  one-cycle strobe; blk_data holds the weight block.
- img_ready  out  1  one-cycle strobe; blk_data holds the image block.
- blk_data  out  [63:0] ×8  last captured block, registered.
- mem_rd_req  out  1  read request, held until granted.
- mem_rd_addr  out  ADDR_W  read block address, registered.
- mem_rd_gnt  in  1  memory has accepted the request.
- mem_rd_valid  in  1  mem_rd_data is valid this cycle.
- mem_rd_data  in  [63:0] ×8  returned block.
- busy  out  1  high in any state other than IDLE, or while any request is pending.
- req_drop  out  1  sticky flag: a request was lost; cleared by start.

## Operation
- Registers:
  - wt_ptr and img_ptr (ADDR_W bits each).
  - wt_pend and img_pend.
  - last_gnt (0 = weight, 1 = image).
  - owner.
  - The state register.
- Pending flags:
  - A req pulse sets the requester's pend flag.
  - A req pulse that arrives while that flag is already set is dropped and sets req_drop.
  - In RESP, the owner's pend flag is cleared. A same-cycle req from the owner wins and re-sets the flag.
- start, IDLE only:
  - wt_ptr ← wt_base, img_ptr ← img_base.
  - last_gnt ← 1, req_drop ← 0.
  - Pending flags are not cleared, so a req in the same cycle is kept.
  - start in any other state is ignored.
- FSM:
  - IDLE: if any pend flag is set, select the owner:
    - Only one flag set: that requester.
    - Both set: the requester that is not last_gnt.
    - Set mem_rd_addr to the owner's pointer, go to ISSUE.
  - ISSUE: mem_rd_req=1, with mem_rd_addr stable. On mem_rd_gnt, go to WAIT.
  - WAIT: on mem_rd_valid, blk_data ← mem_rd_data, go to RESP.
  - RESP:
    - Pulse the owner's ready strobe.
    - Increment the owner's pointer by 1, modulo 2^ADDR_W.
    - last_gnt ← owner.
    - Go to IDLE.
  - An unknown state goes to IDLE.
- mem_rd_valid outside WAIT and mem_rd_gnt outside ISSUE are ignored.
- Only one read is outstanding at a time.

## Timing
- Reset values:
  - All outputs 0: mem_rd_req, mem_rd_addr, wt_ready, img_ready, all blk_data words, busy, req_drop.
  - Internal state: pointers 0, pend flags 0, last_gnt 1, state IDLE.
- Reset asserted mid-transaction: everything returns to reset values immediately. A later mem_rd_valid is ignored.
- From an idle arbiter:
  - A req in cycle t gives pend=1 at t+1 and mem_rd_req=1 from t+2.
  - A grant in cycle g gives WAIT from g+1.
  - mem_rd_valid in cycle v (v ≥ g+1) gives the ready strobe and new blk_data at v+1, and IDLE at v+2.
- Minimum period between back-to-back grants: 4 cycles (IDLE, ISSUE, WAIT, RESP).
- blk_data holds its value until the next capture.
- Ready strobes are exactly one cycle long and are never both high.

## Test plan
- Reset check: assert rst mid-WAIT, then return mem_rd_valid → every output reads 0, no ready pulse, state is IDLE.
- Single weight request: start with wt_base=0x100, then a wt_req pulse.
  - Check mem_rd_addr=0x100 and mem_rd_req high 2 cycles after the req.
  - Grant at once; return valid 3 cycles later with word i = 0xA0+i.
  - Required: wt_ready for one cycle, blk_data[i]=0xA0+i.
  - A second wt_req reads address 0x101.
- Contention: start with wt_base=0x10, img_base=0x80, then wt_req and img_req in the same cycle.
  - Required read order: 0x10, then 0x80.
  - Repeat both requests → 0x11, then 0x81.
- Grant stall: hold mem_rd_gnt low for 5 cycles and pulse mem_rd_valid during ISSUE.
  - Required: mem_rd_req and mem_rd_addr held stable, the stray valid ignored, blk_data unchanged.
- Dropped request: send two wt_req pulses before the grant.
  - Required: one read only and req_drop=1.
  - start in IDLE then clears req_drop; start issued during WAIT has no effect on the pointers.
- Pointer wrap: ADDR_W=8, wt_base=0xFF, two weight reads → addresses 0xFF, then 0x00.

Source files
------------

// File: rtl/dnn_mem_arb_if.sv
// Port bundle of the DNN block-read arbiter: loader request/ready strobes,
// the shared 8x64-bit memory read port, status flags and the FSM debug view.
interface dnn_mem_arb_if #(
    parameter int ADDR_W = 32
);
    logic                 start;
    logic [ADDR_W-1:0]    wt_base;
    logic [ADDR_W-1:0]    img_base;
    logic                 wt_req;
    logic                 img_req;
    logic                 wt_ready;
    logic                 img_ready;
    logic [7:0][63:0]     blk_data;
    logic                 mem_rd_req;
    logic [ADDR_W-1:0]    mem_rd_addr;
    logic                 mem_rd_gnt;
    logic                 mem_rd_valid;
    logic [7:0][63:0]     mem_rd_data;
    logic                 busy;
    logic                 req_drop;
    logic [1:0]           dbg_state;

    // Handshakes: wt_req/img_req are one-cycle pulses; mem_rd_req is held with a
    // stable mem_rd_addr until the cycle mem_rd_gnt is high (transfer happens on
    // that edge); mem_rd_valid/mem_rd_data are a one-cycle response with no back
    // pressure; wt_ready/img_ready are one-cycle strobes qualifying blk_data.

    // The arbiter side: masters the memory port and answers the loaders.
    modport master (
        input  start, wt_base, img_base, wt_req, img_req,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data,
        output wt_ready, img_ready, blk_data,
        output mem_rd_req, mem_rd_addr,
        output busy, req_drop, dbg_state
    );

    // The environment side: loaders plus memory.
    modport slave (
        output start, wt_base, img_base, wt_req, img_req,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data,
        input  wt_ready, img_ready, blk_data,
        input  mem_rd_req, mem_rd_addr,
        input  busy, req_drop, dbg_state
    );
endinterface

// File: rtl/dnn_mem_arb.sv
// Round-robin arbiter sharing one block-read memory port between the weight and
// image loaders; keeps a block pointer per loader and returns captured blocks.
module dnn_mem_arb #(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dnn_mem_arb_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wt_ptr;
    logic [ADDR_W-1:0]   r_img_ptr;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic                r_wt_pend;
    logic                r_img_pend;
    logic                r_last_gnt;
    logic                r_owner;
    logic                r_req_drop;
    logic                r_mem_rd_req;
    logic                r_wt_ready;
    logic                r_img_ready;
    logic [7:0][63:0]    r_blk_data;

    logic                w_idle;
    logic                w_resp;
    logic                w_start;
    logic [ADDR_W-1:0]   w_wt_ptr_eff;
    logic [ADDR_W-1:0]   w_img_ptr_eff;
    logic                w_last_eff;
    logic                w_sel_img;
    logic                w_wt_clr;
    logic                w_img_clr;
    logic                w_wt_drop;
    logic                w_img_drop;

    assign w_idle  = (r_state == S_IDLE);
    assign w_resp  = (r_state == S_RESP);
    assign w_start = bus.start & w_idle;

    // A start in the same IDLE cycle as a selection must already use the new bases.
    assign w_wt_ptr_eff  = w_start ? bus.wt_base  : r_wt_ptr;
    assign w_img_ptr_eff = w_start ? bus.img_base : r_img_ptr;
    assign w_last_eff    = w_start ? 1'b1 : r_last_gnt;
    assign w_sel_img     = r_img_pend & (~r_wt_pend | ~w_last_eff);

    // The owner's flag clears in RESP; a same-cycle req re-arms it and is not a drop.
    assign w_wt_clr   = w_resp & ~r_owner;
    assign w_img_clr  = w_resp &  r_owner;
    assign w_wt_drop  = bus.wt_req  & r_wt_pend  & ~w_wt_clr;
    assign w_img_drop = bus.img_req & r_img_pend & ~w_img_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wt_ptr      <= '0;
            r_img_ptr     <= '0;
            r_mem_rd_addr <= '0;
            r_wt_pend     <= 1'b0;
            r_img_pend    <= 1'b0;
            r_last_gnt    <= 1'b1;
            r_owner       <= 1'b0;
            r_req_drop    <= 1'b0;
            r_mem_rd_req  <= 1'b0;
            r_wt_ready    <= 1'b0;
            r_img_ready   <= 1'b0;
            r_blk_data    <= '0;
        end else begin
            r_wt_pend   <= bus.wt_req  | (r_wt_pend  & ~w_wt_clr);
            r_img_pend  <= bus.img_req | (r_img_pend & ~w_img_clr);
            r_wt_ready  <= 1'b0;
            r_img_ready <= 1'b0;

            if (w_wt_drop | w_img_drop) begin
                r_req_drop <= 1'b1;
            end else if (w_start) begin
                r_req_drop <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_wt_ptr   <= bus.wt_base;
                        r_img_ptr  <= bus.img_base;
                        r_last_gnt <= 1'b1;
                    end
                    if (r_wt_pend | r_img_pend) begin
                        r_owner       <= w_sel_img;
                        r_mem_rd_addr <= w_sel_img ? w_img_ptr_eff : w_wt_ptr_eff;
                        r_mem_rd_req  <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_rd_gnt) begin
                        r_mem_rd_req <= 1'b0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        r_blk_data <= bus.mem_rd_data;
                        if (r_owner) begin
                            r_img_ready <= 1'b1;
                        end else begin
                            r_wt_ready <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_owner) begin
                        r_img_ptr <= r_img_ptr + ADDR_W'(1);
                    end else begin
                        r_wt_ptr <= r_wt_ptr + ADDR_W'(1);
                    end
                    r_last_gnt <= r_owner;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_mem_rd_req <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wt_ready    = r_wt_ready;
    assign bus.img_ready   = r_img_ready;
    assign bus.blk_data    = r_blk_data;
    assign bus.mem_rd_req  = r_mem_rd_req;
    assign bus.mem_rd_addr = r_mem_rd_addr;
    assign bus.busy        = ~w_idle | r_wt_pend | r_img_pend;
    assign bus.req_drop    = r_req_drop;
    assign bus.dbg_state   = r_state;
endmodule
